// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, register-specifier
// width default and the instruction word injected as a bubble.
package pipe_pkg;

  localparam int REG_W_DEF = 5;

  // sll $0,$0,0 -- the canonical MIPS no-op
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADUSE = 2'd1,
    ST_BRWAIT  = 2'd2,
    ST_MULDIV  = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_match.sv
// Source/destination comparator: a source hits a destination only when it is
// actually read, the specifiers agree, and the destination is not $0.
module hazard_match #(
  parameter int REG_W = 5
) (
  input  logic             uses_i,
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] dst_i,
  output logic             match_o
);

  assign match_o = uses_i && (src_i == dst_i) && (dst_i != '0);

endmodule

// File: rtl/hazard_stall.sv
// ID-stage hazard unit: load-use, multiply/divide occupancy and (with
// HAZARD_BRANCH_EN defined) branch-operand hazards, plus a stall counter.
module hazard_stall
  import pipe_pkg::*;
#(
  parameter int MULDIV_LAT = 32,
  parameter int REG_W      = REG_W_DEF
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [REG_W-1:0] ID_RS,
  input  logic [REG_W-1:0] ID_RT,
  input  logic             ID_USES_RS,
  input  logic             ID_USES_RT,
  input  logic             ID_IS_BRANCH,
  input  logic             ID_IS_MULDIV,
  input  logic             IDEXE_MEMREAD,
  input  logic             IDEXE_REGWRITE,
  input  logic [REG_W-1:0] IDEXE_RD,
  input  logic             EXEMEM_MEMREAD,
  input  logic [REG_W-1:0] EXEMEM_RD,
  output logic             STALL_PC,
  output logic             STALL_IFID,
  output logic             BUBBLE_IDEXE,
  output logic             MULDIV_BUSY,
  output logic [15:0]      STALL_CNT,
  output hz_state_e        DBG_STATE
);

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MULDIV_LAT - 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      stall_cnt_q;
  logic             m_rs_ex, m_rt_ex;
  logic             load_use, br_haz, md_block, stall;

  hazard_match #(.REG_W(REG_W)) u_rs_ex (
    .uses_i(ID_USES_RS), .src_i(ID_RS), .dst_i(IDEXE_RD), .match_o(m_rs_ex)
  );
  hazard_match #(.REG_W(REG_W)) u_rt_ex (
    .uses_i(ID_USES_RT), .src_i(ID_RT), .dst_i(IDEXE_RD), .match_o(m_rt_ex)
  );

  assign load_use = IDEXE_MEMREAD && (m_rs_ex || m_rt_ex);

`ifdef HAZARD_BRANCH_EN
  logic m_rs_mem, m_rt_mem;

  hazard_match #(.REG_W(REG_W)) u_rs_mem (
    .uses_i(ID_USES_RS), .src_i(ID_RS), .dst_i(EXEMEM_RD), .match_o(m_rs_mem)
  );
  hazard_match #(.REG_W(REG_W)) u_rt_mem (
    .uses_i(ID_USES_RT), .src_i(ID_RT), .dst_i(EXEMEM_RD), .match_o(m_rt_mem)
  );

  // Branch compares in ID, so a pending ALU result or an in-flight load blocks it
  assign br_haz = ID_IS_BRANCH &&
                  ((IDEXE_REGWRITE && (m_rs_ex || m_rt_ex)) ||
                   (EXEMEM_MEMREAD && (m_rs_mem || m_rt_mem)));
`else
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{ID_IS_BRANCH, IDEXE_REGWRITE, EXEMEM_MEMREAD, EXEMEM_RD};
  assign br_haz = 1'b0;
`endif

  // A new mul/div may issue in the unit's final occupied cycle (counter at 0)
  assign md_block = (state_q == ST_MULDIV) && (cnt_q != '0) && ID_IS_MULDIV;
  assign stall    = RESET && (load_use || br_haz || md_block);

  // Outside an active mul/div countdown every state re-evaluates by priority,
  // so a lower-priority hazard masked this cycle is picked up on the next one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if ((state_q == ST_MULDIV) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (load_use) begin
      state_d = ST_LOADUSE;
    end else if (br_haz) begin
      state_d = ST_BRWAIT;
    end else if (ID_IS_MULDIV) begin
      state_d = ST_MULDIV;
      cnt_d   = LAT_M1;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign STALL_PC     = stall;
  assign STALL_IFID   = stall;
  assign BUBBLE_IDEXE = stall;
  assign MULDIV_BUSY  = (state_q == ST_MULDIV);
  assign STALL_CNT    = stall_cnt_q;
  assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_hazard_stall.sv
// Bench for hazard_stall (MULDIV_LAT=4): directed pipeline scenarios with
// literal expectations, then random traffic checked against a cycle model.
module tb_hazard_stall;
  import pipe_pkg::*;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, idexe_rd = '0, exemem_rd = '0;
  logic       uses_rs = 1'b0, uses_rt = 1'b0, is_branch = 1'b0, is_muldiv = 1'b0;
  logic       idexe_memread = 1'b0, idexe_regwrite = 1'b0, exemem_memread = 1'b0;
  logic       stall_pc, stall_ifid, bubble, busy;
  logic [15:0] stall_cnt;
  hz_state_e  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: mul/div cycles still occupied (including current), stall total
  int md_left   = 0;
  int cnt_model = 0;

  hazard_stall #(.MULDIV_LAT(LAT), .REG_W(5)) dut (
    .CLOCK(clk), .RESET(rst_n),
    .ID_RS(id_rs), .ID_RT(id_rt), .ID_USES_RS(uses_rs), .ID_USES_RT(uses_rt),
    .ID_IS_BRANCH(is_branch), .ID_IS_MULDIV(is_muldiv),
    .IDEXE_MEMREAD(idexe_memread), .IDEXE_REGWRITE(idexe_regwrite), .IDEXE_RD(idexe_rd),
    .EXEMEM_MEMREAD(exemem_memread), .EXEMEM_RD(exemem_rd),
    .STALL_PC(stall_pc), .STALL_IFID(stall_ifid), .BUBBLE_IDEXE(bubble),
    .MULDIV_BUSY(busy), .STALL_CNT(stall_cnt), .DBG_STATE(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit hit(input bit u, input logic [4:0] s, input logic [4:0] d);
    return u && (s == d) && (d != 5'd0);
  endfunction

  // ---------------- scoreboard: model compare every cycle ----------------
  always @(negedge clk) begin
    bit lu, br, st;
    if (!rst_n) begin
      md_left   = 0;
      cnt_model = 0;
      check("rst_stall", {31'd0, stall_pc}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    end else begin
      lu = idexe_memread && (hit(uses_rs, id_rs, idexe_rd) || hit(uses_rt, id_rt, idexe_rd));
`ifdef HAZARD_BRANCH_EN
      br = is_branch &&
           ((idexe_regwrite && (hit(uses_rs, id_rs, idexe_rd) || hit(uses_rt, id_rt, idexe_rd))) ||
            (exemem_memread && (hit(uses_rs, id_rs, exemem_rd) || hit(uses_rt, id_rt, exemem_rd))));
`else
      br = 1'b0;
`endif
      st = lu || br || (is_muldiv && md_left > 1);
      check("stall_pc", {31'd0, stall_pc}, {31'd0, st});
      check("stall_ifid", {31'd0, stall_ifid}, {31'd0, st});
      check("bubble_idexe", {31'd0, bubble}, {31'd0, st});
      check("muldiv_busy", {31'd0, busy}, {31'd0, md_left > 0});
      check("stall_cnt", {16'd0, stall_cnt}, cnt_model);
      // advance model to what the coming rising edge produces
      if (st && cnt_model < 65535) cnt_model++;
      if (is_muldiv && !st) md_left = LAT;
      else if (md_left > 0) md_left--;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; uses_rs = 0; uses_rt = 0;
    is_branch = 0; is_muldiv = 0;
    idexe_memread = 0; idexe_regwrite = 0; idexe_rd = '0;
    exemem_memread = 0; exemem_rd = '0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt);
    id_rs = rs; id_rt = rt; uses_rs = urs; uses_rt = urt;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      if (!busy) done = 1;
      else next_cycle();
    end
    check({name, "_busy_timeout"}, {31'd0, done}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stalls, busies;
    bit issued;

    #3;
    check("reset_stall", {31'd0, stall_pc}, 32'd0);
    check("reset_cnt", {16'd0, stall_cnt}, 32'd0);
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // load $8 in EXE, ADD reads $8: one stall cycle
    set_id(5'd8, 5'd9, 1, 1); idexe_memread = 1; idexe_rd = 5'd8; idexe_regwrite = 1;
    #1 check("lu_stall", {31'd0, stall_pc}, 32'd1);
    next_cycle();
    idexe_memread = 0; idexe_regwrite = 0; idexe_rd = 0;
    exemem_memread = 1; exemem_rd = 5'd8;
    #1 check("lu_released", {31'd0, stall_pc}, 32'd0);
    check("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    next_cycle(); clear_inputs();

    // load to $0 read by ID: never a hazard
    set_id(5'd0, 5'd0, 1, 1); idexe_memread = 1; idexe_rd = 5'd0;
    #1 check("r0_no_stall", {31'd0, stall_pc}, 32'd0);
    next_cycle();
    // matching specifier but source not read
    set_id(5'd7, 5'd7, 0, 0); idexe_rd = 5'd7;
    #1 check("uses_mask", {31'd0, stall_pc}, 32'd0);
    next_cycle(); clear_inputs();

    // back-to-back MULT: busy 4 cycles, second MULT held 3 cycles
    is_muldiv = 1;
    #1 check("mult1_issue", {31'd0, stall_pc}, 32'd0);
    next_cycle();
    stalls = 0; busies = 0; issued = 0;
    for (int i = 0; i < 10 && !issued; i++) begin
      #1;
      if (busy) busies++;
      if (stall_pc) stalls++;
      else issued = 1;
      next_cycle();
    end
    check("mult2_stalls", stalls, 32'd3);
    check("mult1_busy", busies, 32'd4);
    check("mult2_busy", {31'd0, busy}, 32'd1);
    clear_inputs();
    wait_idle("mult2");

    // reset in the second MULDIV cycle
    is_muldiv = 1;
    next_cycle(); is_muldiv = 0;
    next_cycle(); is_muldiv = 1;
    #1 check("md2_stall", {31'd0, stall_pc}, 32'd1);
    rst_n = 1'b0;
    #1 check("async_stall", {31'd0, stall_pc}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_cnt", {16'd0, stall_cnt}, 32'd0);
    next_cycle();
    rst_n = 1'b1; is_muldiv = 0;
    #1 check("post_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("post_rst_stall", {31'd0, stall_pc}, 32'd0);
    next_cycle();

    // load-use together with MULT in ID
    set_id(5'd5, 5'd6, 1, 1); is_muldiv = 1; idexe_memread = 1; idexe_rd = 5'd5;
    #1 check("lu_md_stall", {31'd0, stall_pc}, 32'd1);
    check("lu_md_nobusy", {31'd0, busy}, 32'd0);
    next_cycle();
    idexe_memread = 0; idexe_rd = 0;
    #1 check("lu_md_issue", {31'd0, stall_pc}, 32'd0);
    next_cycle(); clear_inputs();
    #1 check("lu_md_busy", {31'd0, busy}, 32'd1);
    wait_idle("lu_md");

    // BEQ $3,$4: ALU result to $4 in EXE, then load to $3 in MEM
    is_branch = 1; set_id(5'd3, 5'd4, 1, 1); idexe_regwrite = 1; idexe_rd = 5'd4;
`ifdef HAZARD_BRANCH_EN
    #1 check("br_ex_stall", {31'd0, stall_pc}, 32'd1);
`else
    #1 check("br_ex_stall", {31'd0, stall_pc}, 32'd0);
`endif
    next_cycle();
    idexe_regwrite = 0; idexe_rd = 0; exemem_memread = 1; exemem_rd = 5'd3;
`ifdef HAZARD_BRANCH_EN
    #1 check("br_mem_stall", {31'd0, stall_pc}, 32'd1);
`else
    #1 check("br_mem_stall", {31'd0, stall_pc}, 32'd0);
`endif
    next_cycle();
    exemem_memread = 0; exemem_rd = 0;
    #1 check("br_clear", {31'd0, stall_pc}, 32'd0);
    next_cycle(); clear_inputs();

    // random traffic, small register range to provoke matches
    for (int c = 0; c < 2000; c++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      id_rs          = 5'($urandom_range(0, 3));
      id_rt          = 5'($urandom_range(0, 3));
      uses_rs        = 1'($urandom_range(0, 1));
      uses_rt        = 1'($urandom_range(0, 1));
      is_branch      = ($urandom_range(0, 3) == 0);
      is_muldiv      = ($urandom_range(0, 2) == 0);
      idexe_memread  = ($urandom_range(0, 3) == 0);
      idexe_regwrite = 1'($urandom_range(0, 1));
      idexe_rd       = 5'($urandom_range(0, 3));
      exemem_memread = ($urandom_range(0, 3) == 0);
      exemem_rd      = 5'($urandom_range(0, 3));
      next_cycle();
    end
    rst_n = 1'b1;
    clear_inputs();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall.md
HAZARD_STALL -- requirements
Module: hazard_stall

Interface
REQ-001 Parameter MULDIV_LAT, default 32, meaning EXE-stage cycles occupied by one multiply/divide (range 2..63).
REQ-002 Parameter REG_W, default 5, meaning register-specifier width.
REQ-003 CLOCK  input  1  pipeline clock, state updates on rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-low.
REQ-005 ID_RS, ID_RT  input  REG_W each  source specifiers of the instruction in ID.
REQ-006 ID_USES_RS, ID_USES_RT  input  1 each  ID instruction reads that source.
REQ-007 ID_IS_BRANCH  input  1  ID instruction is a branch that compares its operands in ID.
REQ-008 ID_IS_MULDIV  input  1  ID instruction is multiply/divide.
REQ-009 IDEXE_MEMREAD, IDEXE_REGWRITE  input  1 each  EXE-stage instruction is a load / writes a register.
REQ-010 IDEXE_RD  input  REG_W  EXE-stage destination.
REQ-011 EXEMEM_MEMREAD  input  1  MEM-stage instruction is a load.
REQ-012 EXEMEM_RD  input  REG_W  MEM-stage destination.
REQ-013 STALL_PC, STALL_IFID  output  1 each  hold PC and IF/ID register.
REQ-014 BUBBLE_IDEXE  output  1  load a NOP into ID/EXE.
REQ-015 MULDIV_BUSY  output  1  multiply/divide unit occupied.
REQ-016 STALL_CNT  output  16  saturating count of stall cycles since reset.

Function
REQ-017 A source matches a destination only when its USES bit is 1, the specifiers are equal, and the destination is non-zero; register 0 never causes a hazard.
REQ-018 Load-use hazard: IDEXE_MEMREAD=1 and IDEXE_RD matches ID_RS or ID_RT.
REQ-019 FSM states: IDLE, LOADUSE, BRWAIT, MULDIV; encoded in package enum.
REQ-020 IDLE -> LOADUSE on load-use hazard; LOADUSE lasts exactly one cycle, then -> IDLE.
REQ-021 IDLE -> MULDIV when ID_IS_MULDIV=1 with no other hazard; counter loads MULDIV_LAT-1 and decrements each cycle; MULDIV -> IDLE when the counter reaches 0.
REQ-022 In MULDIV, an ID instruction with ID_IS_MULDIV=1 asserts stall; any other instruction proceeds.
REQ-023 STALL_PC = STALL_IFID = BUBBLE_IDEXE = 1 combinationally in the same cycle a hazard is detected (hazard-in-IDLE or stall condition in the current state); no extra cycle of latency.
REQ-024 MULDIV_BUSY = 1 exactly while state is MULDIV.
REQ-025 Priority when several hazards coexist: load-use > branch > muldiv; a lower-priority hazard is re-evaluated next cycle.
REQ-026 STALL_CNT increments on each rising edge with STALL_PC=1 and saturates at 16'hFFFF.
REQ-027 Outputs are free of X when inputs are known; unused USES bits mask the corresponding specifier.

Reset
REQ-028 RESET=0 immediately forces state IDLE, counter 0, STALL_CNT 0, and all stall/bubble/busy outputs 0, independent of CLOCK.
REQ-029 Reset asserted mid-MULDIV or mid-BRWAIT abandons the operation; no stall is asserted on the first cycle after release unless a new hazard is present.

Configuration
REQ-030 Macro HAZARD_BRANCH_EN defined: branch hazard = ID_IS_BRANCH=1 and (IDEXE_REGWRITE=1 with IDEXE_RD match, or EXEMEM_MEMREAD=1 with EXEMEM_RD match); IDLE -> BRWAIT, stall asserted in BRWAIT while the condition holds, -> IDLE when clear.
REQ-031 Macro undefined: BRWAIT state and branch logic absent; ID_IS_BRANCH ignored; branches resolve via forwarding only.

Structure
REQ-032 Shared package pipe_pkg holds the state enum, REG_W default, and the NOP encoding used for bubbles.
REQ-033 One sub-module, hazard_match, implements the REQ-017 comparator and is instantiated per source/destination pair.

Verification
REQ-034 LW to $8 in EXE, ID ADD reads $8 -> STALL_PC/STALL_IFID/BUBBLE_IDEXE = 1 for exactly 1 cycle, STALL_CNT = 1.
REQ-035 LW to $0 in EXE, ID reads $0 -> no stall.
REQ-036 MULT issued (MULDIV_LAT=4), next MULT arrives immediately -> MULDIV_BUSY high 4 cycles, second MULT stalled 3 cycles.
REQ-037 HAZARD_BRANCH_EN defined: BEQ $3,$4 in ID, EXE writes $4 -> stall 1 cycle; MEM load to $3 next -> stall 1 more cycle; undefined -> no stall.
REQ-038 RESET pulsed low during MULDIV cycle 2 -> all outputs 0 asynchronously, state IDLE after release.
REQ-039 Load-use and MULT in ID simultaneously -> load-use stall first cycle, MULDIV entered second cycle.
